// File: rtl/onchip_arb_pkg.sv
// onchip_arb_pkg -- shared types and default sizes for the two-requester
// on-chip memory arbiter (onchip_mem_arbiter / onchip_arb_grant).
//   arb_state_t : arbiter ownership state (IDLE, OWN0, OWN1)
//   req_idx_t   : index of a requester (0 or 1)
//   DEF_*       : default ADDR_W / DATA_W / HOLD_MAX
package onchip_arb_pkg;

   localparam int DEF_ADDR_W   = 16;
   localparam int DEF_DATA_W   = 32;
   localparam int DEF_HOLD_MAX = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } arb_state_t;

   typedef logic req_idx_t;

endpackage

// File: rtl/onchip_arb_grant.sv
// onchip_arb_grant -- grant decision for two requesters.
// Holds ownership state, hold counter and round-robin pointer; the grant
// itself is combinational from the current state and the requests.
// Ports:
//   clk, reset_n : clock, synchronous active-low reset
//   req[1:0]     : per-requester request (in)
//   gnt[1:0]     : one-hot grant, zero during reset (out)
// Build option: ONCHIP_ARB_FIXED_PRIO_EN -- requester 1 wins every contested
// cycle and the hold limit no longer affects who is granted.
module onchip_arb_grant
   import onchip_arb_pkg::*;
#(
   parameter int HOLD_MAX = DEF_HOLD_MAX
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [1:0] req,
   output logic [1:0] gnt
);

   localparam int CNT_W = $clog2(HOLD_MAX + 1);
   localparam logic [CNT_W-1:0] HMAX = CNT_W'(HOLD_MAX);

   arb_state_t       state_q, state_d;
   logic [CNT_W-1:0] hold_q, hold_d, sat_inc;
   req_idx_t         last_q, last_d;
   req_idx_t         own, g;
   logic             gv;

   assign sat_inc = (hold_q == HMAX) ? hold_q : hold_q + 1'b1;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= IDLE;
         hold_q  <= '0;
         last_q  <= 1'b1;   // requester 0 wins the first tie
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         last_q  <= last_d;
      end
   end

   always_comb begin
      gnt     = '0;
      state_d = state_q;
      hold_d  = hold_q;
      last_d  = last_q;
      gv      = 1'b0;
      g       = 1'b0;
      own     = (state_q == OWN1);
`ifdef ONCHIP_ARB_FIXED_PRIO_EN
      if (req[1]) begin
         gv = 1'b1;
         g  = 1'b1;
      end else if (req[0]) begin
         gv = 1'b1;
         g  = 1'b0;
      end
      // counter still tracks consecutive grants, it just never forces a switch
      if (gv) hold_d = (state_q != IDLE && g == own) ? sat_inc : CNT_W'(1);
`else
      case (state_q)
         OWN0, OWN1: begin
            if (req[own]) begin
               gv = 1'b1;
               if (!req[~own]) begin
                  g      = own;
                  hold_d = sat_inc;
               end else if (hold_q < HMAX) begin
                  g      = own;
                  hold_d = hold_q + 1'b1;
               end else begin
                  g      = ~own;
                  hold_d = CNT_W'(1);
               end
            end else if (req[~own]) begin
               gv     = 1'b1;
               g      = ~own;
               hold_d = CNT_W'(1);
            end
         end
         default: begin
            // IDLE: a tie goes to whoever was not granted last
            gv     = |req;
            g      = (req[0] && req[1]) ? ~last_q : req[1];
            hold_d = CNT_W'(1);
         end
      endcase
`endif
      if (gv) begin
         gnt[g]  = 1'b1;
         state_d = g ? OWN1 : OWN0;
         last_d  = g;
      end else begin
         state_d = IDLE;
         hold_d  = '0;
      end
      if (!reset_n) gnt = '0;
   end

endmodule

// File: rtl/onchip_mem_arbiter.sv
// onchip_mem_arbiter -- shares one single-port on-chip memory between two
// Avalon-MM style requesters.
// Ports:
//   clk, reset_n           : clock, synchronous active-low reset
//   mN_chipselect/read/write/address/byteenable/writedata : requester N cmd
//   mN_waitrequest         : request pending but not granted this cycle
//   mN_readdatavalid       : one-cycle pulse, read data for requester N
//   mN_readdata            : shared memory read data (qualify with valid)
//   mem_*                  : memory side; granted requester's fields
//   mem_clken              : memory clock enable, low only during reset
// Build option: ONCHIP_ARB_FIXED_PRIO_EN (see onchip_arb_grant).
module onchip_mem_arbiter
   import onchip_arb_pkg::*;
#(
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int DATA_W   = DEF_DATA_W,
   parameter int HOLD_MAX = DEF_HOLD_MAX
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                m0_chipselect,
   input  logic                m0_read,
   input  logic                m0_write,
   input  logic [ADDR_W-1:0]   m0_address,
   input  logic [DATA_W/8-1:0] m0_byteenable,
   input  logic [DATA_W-1:0]   m0_writedata,
   output logic                m0_waitrequest,
   output logic                m0_readdatavalid,
   output logic [DATA_W-1:0]   m0_readdata,
   input  logic                m1_chipselect,
   input  logic                m1_read,
   input  logic                m1_write,
   input  logic [ADDR_W-1:0]   m1_address,
   input  logic [DATA_W/8-1:0] m1_byteenable,
   input  logic [DATA_W-1:0]   m1_writedata,
   output logic                m1_waitrequest,
   output logic                m1_readdatavalid,
   output logic [DATA_W-1:0]   m1_readdata,
   output logic [ADDR_W-1:0]   mem_address,
   output logic [DATA_W/8-1:0] mem_byteenable,
   output logic                mem_chipselect,
   output logic                mem_write,
   output logic [DATA_W-1:0]   mem_writedata,
   output logic                mem_clken,
   input  logic [DATA_W-1:0]   mem_readdata
);

   logic [1:0] req, wr, rd_only, gnt, rdv_q;

   // read+write together counts as a write
   assign wr      = {m1_write, m0_write};
   assign rd_only = {m1_read & ~m1_write, m0_read & ~m0_write};
   assign req     = {m1_chipselect & (m1_read | m1_write),
                     m0_chipselect & (m0_read | m0_write)};

   onchip_arb_grant #(.HOLD_MAX(HOLD_MAX)) u_grant (
      .clk     (clk),
      .reset_n (reset_n),
      .req     (req),
      .gnt     (gnt)
   );

   assign m0_waitrequest = req[0] & ~gnt[0];
   assign m1_waitrequest = req[1] & ~gnt[1];

   // gnt is one-hot or zero, so gnt[1] alone selects the source
   assign mem_address    = gnt[1] ? m1_address    : m0_address;
   assign mem_byteenable = gnt[1] ? m1_byteenable : m0_byteenable;
   assign mem_writedata  = gnt[1] ? m1_writedata  : m0_writedata;
   assign mem_chipselect = |gnt;
   assign mem_write      = |(gnt & wr);
   assign mem_clken      = reset_n;

   // memory has one cycle of read latency; valid follows the granted read
   always_ff @(posedge clk) begin
      if (!reset_n) rdv_q <= '0;
      else          rdv_q <= gnt & rd_only;
   end

   assign m0_readdatavalid = rdv_q[0];
   assign m1_readdatavalid = rdv_q[1];
   assign m0_readdata      = mem_readdata;
   assign m1_readdata      = mem_readdata;

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// tb_onchip_mem_arbiter -- self-checking bench for onchip_mem_arbiter.
// A behavioural single-port memory sits on the mem_* side; a shadow copy
// supplies expected read data, queued per requester at grant time and
// popped when readdatavalid is due.
module tb_onchip_mem_arbiter;
   import onchip_arb_pkg::*;

   localparam int AW = 16;
   localparam int DW = 32;
   localparam int BW = DW / 8;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          cs [2], rd [2], wr [2];
   logic [AW-1:0] addr [2];
   logic [BW-1:0] be [2];
   logic [DW-1:0] wd [2];
   logic          waitreq [2], rdv [2];
   logic [DW-1:0] rdata [2];
   logic [AW-1:0] mem_address;
   logic [BW-1:0] mem_byteenable;
   logic          mem_chipselect, mem_write, mem_clken;
   logic [DW-1:0] mem_writedata, mem_readdata;

   logic [DW-1:0] mem [1024];
   logic [DW-1:0] shadow [1024];
   logic [DW-1:0] q0 [$];
   logic [DW-1:0] q1 [$];
   logic [1:0]    exp_rdv = 2'b00;
   int            checks = 0;
   int            errors = 0;

   always #5 clk = ~clk;

   onchip_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .HOLD_MAX(4)) dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .m0_chipselect    (cs[0]),
      .m0_read          (rd[0]),
      .m0_write         (wr[0]),
      .m0_address       (addr[0]),
      .m0_byteenable    (be[0]),
      .m0_writedata     (wd[0]),
      .m0_waitrequest   (waitreq[0]),
      .m0_readdatavalid (rdv[0]),
      .m0_readdata      (rdata[0]),
      .m1_chipselect    (cs[1]),
      .m1_read          (rd[1]),
      .m1_write         (wr[1]),
      .m1_address       (addr[1]),
      .m1_byteenable    (be[1]),
      .m1_writedata     (wd[1]),
      .m1_waitrequest   (waitreq[1]),
      .m1_readdatavalid (rdv[1]),
      .m1_readdata      (rdata[1]),
      .mem_address      (mem_address),
      .mem_byteenable   (mem_byteenable),
      .mem_chipselect   (mem_chipselect),
      .mem_write        (mem_write),
      .mem_writedata    (mem_writedata),
      .mem_clken        (mem_clken),
      .mem_readdata     (mem_readdata)
   );

   // single-port memory, one cycle read latency
   always @(posedge clk) begin
      if (mem_clken && mem_chipselect) begin
         if (mem_write) begin
            for (int b = 0; b < BW; b++)
               if (mem_byteenable[b]) mem[mem_address[9:0]][8*b +: 8] <= mem_writedata[8*b +: 8];
         end else begin
            mem_readdata <= mem[mem_address[9:0]];
         end
      end
   end

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%h exp=%h t=%0t", tag, act, exp, $time);
      end
   endtask

   task automatic set_req(input int i, input logic r, input logic w,
                          input logic [AW-1:0] a, input logic [BW-1:0] b, input logic [DW-1:0] d);
      cs[i] = 1'b1; rd[i] = r; wr[i] = w; addr[i] = a; be[i] = b; wd[i] = d;
   endtask

   task automatic clr();
      for (int i = 0; i < 2; i++) begin
         cs[i] = 1'b0; rd[i] = 1'b0; wr[i] = 1'b0; addr[i] = '0; be[i] = '0; wd[i] = '0;
      end
   endtask

   // one bus cycle: inputs already driven; eg = expected one-hot grant
   task automatic step(input logic [1:0] eg);
      logic [1:0]    nxt;
      logic [DW-1:0] e;
      nxt = 2'b00;
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("rdv%0d", i), 64'(rdv[i]), 64'(exp_rdv[i]));
         if (exp_rdv[i]) begin
            e = (i == 0) ? q0.pop_front() : q1.pop_front();
            chk($sformatf("rdata%0d", i), 64'(rdata[i]), 64'(e));
         end
         chk($sformatf("wait%0d", i), 64'(waitreq[i]), 64'(cs[i] & (rd[i] | wr[i]) & ~eg[i]));
      end
      chk("mem_cs", 64'(mem_chipselect), 64'(|eg));
      chk("clken", 64'(mem_clken), 64'(reset_n));
      for (int i = 0; i < 2; i++) begin
         if (eg[i]) begin
            chk("mem_addr", 64'(mem_address), 64'(addr[i]));
            chk("mem_wr", 64'(mem_write), 64'(wr[i]));
            if (wr[i]) begin
               for (int b = 0; b < BW; b++)
                  if (be[i][b]) shadow[addr[i][9:0]][8*b +: 8] = wd[i][8*b +: 8];
            end else begin
               if (i == 0) q0.push_back(shadow[addr[i][9:0]]);
               else        q1.push_back(shadow[addr[i][9:0]]);
               nxt[i] = 1'b1;
            end
         end
      end
      @(posedge clk);
      exp_rdv = nxt;
      #1;
   endtask

   // both requesters streaming reads; exp_owner computes expected grant per cycle
   task automatic stream(input int n, input bit alone_m0_first);
      int            k0, k1;
      logic          o;
      k0 = 0; k1 = 0;
      for (int k = 0; k < n; k++) begin
         set_req(0, 1'b1, 1'b0, AW'(16'h0020 + k0), '1, '0);
         set_req(1, 1'b1, 1'b0, AW'(16'h0040 + k1), '1, '0);
`ifdef ONCHIP_ARB_FIXED_PRIO_EN
         o = 1'b1;
`else
         // from fresh IDLE: 4x m0 then 4x m1; after m0 has saturated its
         // hold alone, the first contested cycle already goes to m1
         o = alone_m0_first ? (((k / 4) % 2) == 0) : (((k / 4) % 2) == 1);
`endif
         step(o ? 2'b10 : 2'b01);
         if (o) k1++; else k0++;
      end
   endtask

   initial begin
      for (int k = 0; k < 1024; k++) begin
         mem[k]    = 32'hA500_0000 | k;
         shadow[k] = 32'hA500_0000 | k;
      end
      clr();
      reset_n = 1'b0;
      // reset: requests present, everything suppressed
      set_req(0, 1'b1, 1'b0, 16'h0004, '1, '0);
      set_req(1, 1'b0, 1'b1, 16'h0008, '1, 32'h1111_1111);
      step(2'b00);
      step(2'b00);
      chk("rst_state", 64'(dut.u_grant.state_q), 64'(IDLE));
      reset_n = 1'b1;

      // lone m0 read, data one cycle later
      clr();
      set_req(0, 1'b1, 1'b0, 16'h0010, '1, '0);
      step(2'b01);
      clr();
      step(2'b00);

      // fresh reset, then both stream
      reset_n = 1'b0;
      step(2'b00);
      reset_n = 1'b1;
`ifdef ONCHIP_ARB_FIXED_PRIO_EN
      stream(16, 1'b1);
`else
      stream(16, 1'b0);
`endif
      clr();
      step(2'b00);

      // m0 saturates its hold alone, then m1 joins
      for (int k = 0; k < 6; k++) begin
         set_req(0, 1'b1, 1'b0, AW'(16'h0060 + k), '1, '0);
         step(2'b01);
      end
      stream(6, 1'b1);
      clr();
      step(2'b00);

      // partial write then read-back
      set_req(1, 1'b0, 1'b1, 16'h0100, 4'h3, 32'hDEAD_BEEF);
      step(2'b10);
      clr();
      set_req(0, 1'b1, 1'b0, 16'h0100, '1, '0);
      step(2'b01);
      clr();
      step(2'b00);
      chk("beef_lo", 64'(rdata[0][15:0]), 64'h0000_BEEF);
      chk("beef_hi", 64'(rdata[0][31:16]), 64'h0000_A500);

      // read and write together act as a write
      set_req(0, 1'b1, 1'b1, 16'h0200, '1, 32'h1234_5678);
      step(2'b01);
      clr();
      set_req(0, 1'b1, 1'b0, 16'h0200, '1, '0);
      step(2'b01);
      clr();
      step(2'b00);
      chk("rw_data", 64'(rdata[0]), 64'h1234_5678);

      // m1 read during reset: no response after release
      set_req(1, 1'b1, 1'b0, 16'h0300, '1, '0);
      reset_n = 1'b0;
      step(2'b00);
      reset_n = 1'b1;
      clr();
      step(2'b00);
      chk("rst_rdv1", 64'(rdv[1]), 64'h0);
      chk("rst_idle", 64'(dut.u_grant.state_q), 64'(IDLE));
      set_req(0, 1'b1, 1'b0, 16'h0310, '1, '0);
      set_req(1, 1'b1, 1'b0, 16'h0320, '1, '0);
`ifdef ONCHIP_ARB_FIXED_PRIO_EN
      step(2'b10);
`else
      step(2'b01);
`endif
      clr();
      step(2'b00);
      step(2'b00);
      chk("q_empty", 64'(q0.size() + q1.size()), 64'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/onchip_mem_arbiter.md
ONCHIP_MEM_ARBITER -- requirements
Module: onchip_mem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 16, meaning the memory word-address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning the data width; byteenable width is DATA_W/8.
REQ-003 The block SHALL have parameter HOLD_MAX, default 4, meaning the maximum consecutive contested cycles one owner keeps the grant.
REQ-004 The block SHALL have ports clk (in, 1, clock) and reset_n (in, 1, reset); one clock, synchronous active-low reset.
REQ-005 The block SHALL have, per requester i in {0,1}: mi_chipselect in 1, mi_read in 1, mi_write in 1, mi_address in ADDR_W, mi_byteenable in DATA_W/8, mi_writedata in DATA_W, mi_waitrequest out 1, mi_readdatavalid out 1, mi_readdata out DATA_W.
REQ-006 The block SHALL have memory-side ports: mem_address out ADDR_W, mem_byteenable out DATA_W/8, mem_chipselect out 1, mem_write out 1, mem_writedata out DATA_W, mem_clken out 1, mem_readdata in DATA_W.

Function
REQ-007 Request from requester i SHALL be reqi = mi_chipselect & (mi_read | mi_write); read and write both high SHALL be treated as a write.
REQ-008 Arbiter state SHALL be IDLE, OWN0 or OWN1, plus hold counter hold_cnt (0..HOLD_MAX) and round-robin pointer last.
REQ-009 Grant SHALL be combinational from current state and requests; memory ports SHALL carry the granted requester's fields in the same cycle; mem_chipselect = 1 only when a grant is issued.
REQ-010 mi_waitrequest SHALL equal reqi & ~granti, combinationally.
REQ-011 IDLE: one request -> grant it; both -> grant the requester not equal to last; none -> stay IDLE.
REQ-012 OWNi with reqi: if other requester idle -> grant i, hold_cnt saturates at HOLD_MAX; if other requesting and hold_cnt < HOLD_MAX -> grant i, hold_cnt+1; if other requesting and hold_cnt = HOLD_MAX -> grant other, move to OWN(other), hold_cnt=1.
REQ-013 OWNi without reqi: other requesting -> grant other, hold_cnt=1; none -> IDLE, hold_cnt=0.
REQ-014 On every grant, last SHALL update to the granted index.
REQ-015 mem_readdata SHALL be returned one cycle after a granted read; mi_readdatavalid SHALL be a register set one cycle after a granted read by requester i, high exactly one cycle per read.
REQ-016 mi_readdata SHALL be mem_readdata for both requesters; only readdatavalid qualifies.
REQ-017 Back-to-back granted reads SHALL produce back-to-back readdatavalid pulses, throughput one access per cycle.
REQ-018 mem_clken SHALL be 1 whenever reset_n is 1, 0 during reset.
REQ-019 Writes SHALL complete in the grant cycle; no response signal.

Reset
REQ-020 On reset_n=0 at a clk edge: state IDLE, hold_cnt 0, last 1 (requester 0 wins first tie), both readdatavalid 0.
REQ-021 A read granted in the cycle reset asserts SHALL produce no readdatavalid after reset releases.
REQ-022 During reset, grants SHALL be suppressed: mem_chipselect 0, mem_write 0, all waitrequest = req.

Configuration
REQ-023 Macro ONCHIP_ARB_FIXED_PRIO_EN defined: requester 1 SHALL win every contested cycle, HOLD_MAX ignored; undefined: round-robin with hold per REQ-011..013.

Structure
REQ-024 Package onchip_arb_pkg SHALL hold the state enum (IDLE, OWN0, OWN1), requester-index typedef and default ADDR_W/DATA_W/HOLD_MAX constants.
REQ-025 Grant logic (state, hold_cnt, last) SHALL live in sub-module onchip_arb_grant; the top holds the datapath mux and readdatavalid registers.

Verification
REQ-026 Reset release, m0 read addr 0x0010 alone -> granted same cycle, m0_readdatavalid one cycle later with memory word at 0x0010.
REQ-027 Both request from IDLE after reset -> m0 granted first, m1_waitrequest=1.
REQ-028 Both stream continuous reads, HOLD_MAX=4 -> grant pattern 4x m0, 4x m1, repeating; readdatavalid pulses match.
REQ-029 m1 write 0xDEADBEEF byteenable 0x3 to 0x0100, then m0 read 0x0100 -> m0 readdata low halfword 0xBEEF, upper bytes unchanged.
REQ-030 reset_n low in cycle of granted m1 read -> m1_readdatavalid stays 0 after release, state IDLE.
REQ-031 With ONCHIP_ARB_FIXED_PRIO_EN, both streaming -> m1 granted every cycle, m0_waitrequest held 1.
